// File: rtl/sargantana_icache_fill_ctrl.sv
// Sargantana instruction-cache refill controller.
// Picks a victim way, requests the line from L2, installs it and services invalidations.
module sargantana_icache_fill_ctrl #(
    parameter int N_WAY   = 4,
    parameter int IDX_W   = 7,
    parameter int TAG_W   = 20,
    parameter int PADDR_W = 40,
    parameter int LINE_W  = 256,
    parameter int WAY_W   = (N_WAY > 1) ? $clog2(N_WAY) : 1
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               miss_valid_i,
    input  logic [PADDR_W-1:0] miss_paddr_i,
    output logic               miss_ready_o,
    input  logic               kill_i,
    input  logic [N_WAY-1:0]   way_valid_i,
    output logic               ifill_req_valid_o,
    output logic [WAY_W-1:0]   ifill_req_way_o,
    output logic [PADDR_W-1:0] ifill_req_paddr_o,
    input  logic               ifill_ack_i,
    input  logic               ifill_resp_valid_i,
    input  logic [LINE_W-1:0]  ifill_data_i,
    input  logic               inv_valid_i,
    input  logic [11:0]        inv_paddr_i,
    output logic [N_WAY-1:0]   wr_en_o,
    output logic [IDX_W-1:0]   wr_idx_o,
    output logic [TAG_W-1:0]   wr_tag_o,
    output logic [LINE_W-1:0]  wr_data_o,
    output logic               wr_vbit_o,
    output logic               fill_done_o,
    output logic               busy_o,
    output logic               inv_ovf_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_WAIT, S_WRITE, S_INV
    } state_e;

    state_e             state_q;
    logic [PADDR_W-1:0] paddr_q;
    logic [WAY_W-1:0]   way_q;
    logic [WAY_W-1:0]   rr_q;
    logic [LINE_W-1:0]  line_q;
    logic               drop_q;
    logic               pend_q;
    logic [IDX_W-1:0]   inv_idx_q;
    logic               ovf_q;

    logic [WAY_W-1:0]   victim_d;
    logic [WAY_W-1:0]   rr_d;
    logic [IDX_W-1:0]   inv_idx;
    logic [IDX_W-1:0]   fill_idx;
    logic               in_flight;
    logic               inv_hit;
    logic               drop_now;
    logic               unused_bits;

    assign inv_idx     = inv_paddr_i[5 +: IDX_W];
    assign fill_idx    = paddr_q[5 +: IDX_W];
    assign in_flight   = (state_q == S_REQ) || (state_q == S_WAIT);
    // An invalidation of the set being filled makes the incoming line stale.
    assign inv_hit     = inv_valid_i && in_flight && (inv_idx == fill_idx);
    assign drop_now    = drop_q || kill_i || inv_hit;
    assign rr_d        = (rr_q == WAY_W'(N_WAY - 1)) ? '0 : rr_q + 1'b1;
    assign unused_bits = ^{miss_paddr_i[4:0], inv_paddr_i[4:0]};

    // Victim: lowest invalid way, else the round-robin pointer.
    always_comb begin
        victim_d = rr_q;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (!way_valid_i[i]) victim_d = WAY_W'(i);
        end
    end

    // Refill FSM, one-entry invalidation queue and round-robin pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            paddr_q   <= '0;
            way_q     <= '0;
            rr_q      <= '0;
            line_q    <= '0;
            drop_q    <= 1'b0;
            pend_q    <= 1'b0;
            inv_idx_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (state_q == S_INV) pend_q <= 1'b0;
            if (inv_valid_i) begin
                if (!pend_q || state_q == S_INV) begin
                    pend_q    <= 1'b1;
                    inv_idx_q <= inv_idx;
                end else begin
                    ovf_q <= 1'b1;
                end
            end
            unique case (state_q)
                S_IDLE: begin
                    if (pend_q) begin
                        state_q <= S_INV;
                    end else if (miss_valid_i && !inv_valid_i) begin
                        paddr_q <= {miss_paddr_i[PADDR_W-1:5], 5'd0};
                        way_q   <= victim_d;
                        drop_q  <= 1'b0;
                        if (&way_valid_i) rr_q <= rr_d;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (kill_i || inv_hit) drop_q <= 1'b1;
                    if (ifill_ack_i) state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (kill_i || inv_hit) drop_q <= 1'b1;
                    if (ifill_resp_valid_i) begin
                        line_q  <= ifill_data_i;
                        state_q <= drop_now ? S_IDLE : S_WRITE;
                    end
                end
                S_WRITE: state_q <= S_IDLE;
                S_INV:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign miss_ready_o      = !rst_i && (state_q == S_IDLE) &&
                               !pend_q && !inv_valid_i;
    assign ifill_req_valid_o = (state_q == S_REQ);
    assign ifill_req_way_o   = way_q;
    assign ifill_req_paddr_o = paddr_q;

    // Write port: single-way install in WRITE, whole-set clear in INV.
    always_comb begin
        wr_en_o     = '0;
        wr_idx_o    = '0;
        wr_tag_o    = '0;
        wr_data_o   = '0;
        wr_vbit_o   = 1'b0;
        fill_done_o = 1'b0;
        if (state_q == S_WRITE) begin
            wr_en_o     = N_WAY'(1) << way_q;
            wr_idx_o    = fill_idx;
            wr_tag_o    = paddr_q[12 +: TAG_W];
            wr_data_o   = line_q;
            wr_vbit_o   = 1'b1;
            fill_done_o = 1'b1;
        end else if (state_q == S_INV) begin
            wr_en_o  = '1;
            wr_idx_o = inv_idx_q;
        end
    end

    assign busy_o    = (state_q != S_IDLE);
    assign inv_ovf_o = ovf_q;

endmodule

// File: tb/tb_sargantana_icache_fill_ctrl.sv
// Directed bench for sargantana_icache_fill_ctrl.
// Expected values are hand-computed constants from the documented behaviour.
module tb_sargantana_icache_fill_ctrl;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         miss_valid_i;
    logic [39:0]  miss_paddr_i;
    logic         miss_ready_o;
    logic         kill_i;
    logic [3:0]   way_valid_i;
    logic         ifill_req_valid_o;
    logic [1:0]   ifill_req_way_o;
    logic [39:0]  ifill_req_paddr_o;
    logic         ifill_ack_i;
    logic         ifill_resp_valid_i;
    logic [255:0] ifill_data_i;
    logic         inv_valid_i;
    logic [11:0]  inv_paddr_i;
    logic [3:0]   wr_en_o;
    logic [6:0]   wr_idx_o;
    logic [19:0]  wr_tag_o;
    logic [255:0] wr_data_o;
    logic         wr_vbit_o;
    logic         fill_done_o;
    logic         busy_o;
    logic         inv_ovf_o;

    int n_tot = 0;
    int n_bad = 0;

    sargantana_icache_fill_ctrl dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .miss_valid_i(miss_valid_i), .miss_paddr_i(miss_paddr_i),
        .miss_ready_o(miss_ready_o), .kill_i(kill_i),
        .way_valid_i(way_valid_i),
        .ifill_req_valid_o(ifill_req_valid_o),
        .ifill_req_way_o(ifill_req_way_o),
        .ifill_req_paddr_o(ifill_req_paddr_o),
        .ifill_ack_i(ifill_ack_i),
        .ifill_resp_valid_i(ifill_resp_valid_i),
        .ifill_data_i(ifill_data_i),
        .inv_valid_i(inv_valid_i), .inv_paddr_i(inv_paddr_i),
        .wr_en_o(wr_en_o), .wr_idx_o(wr_idx_o), .wr_tag_o(wr_tag_o),
        .wr_data_o(wr_data_o), .wr_vbit_o(wr_vbit_o),
        .fill_done_o(fill_done_o), .busy_o(busy_o),
        .inv_ovf_o(inv_ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [255:0] got,
                         input logic [255:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are then driven 1 ns after the edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Full refill with immediate ack and response in the first WAIT cycle.
    task automatic do_fill(input string tag, input logic [39:0] pa,
                           input logic [39:0] pa_al, input logic [3:0] wv,
                           input logic [1:0] way, input logic [3:0] en);
        logic [255:0] line;
        line = {8{pa[31:0]}};
        miss_valid_i = 1'b1;
        miss_paddr_i = pa;
        way_valid_i  = wv;
        #1 check({tag, ".ready"}, miss_ready_o, 1'b1);
        tick();
        miss_valid_i = 1'b0;
        ifill_ack_i  = 1'b1;
        #1;
        check({tag, ".rq_v"}, ifill_req_valid_o, 1'b1);
        check({tag, ".rq_way"}, ifill_req_way_o, way);
        check({tag, ".rq_pa"}, ifill_req_paddr_o, pa_al);
        tick();
        ifill_ack_i        = 1'b0;
        ifill_resp_valid_i = 1'b1;
        ifill_data_i       = line;
        #1 check({tag, ".wait_rq"}, ifill_req_valid_o, 1'b0);
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check({tag, ".wr_en"}, wr_en_o, en);
        check({tag, ".done"}, fill_done_o, 1'b1);
        check({tag, ".data"}, wr_data_o, line);
        tick();
        #1 check({tag, ".idle_en"}, wr_en_o, 4'b0000);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; miss_valid_i = 1'b0; miss_paddr_i = '0;
        kill_i = 1'b0; way_valid_i = '0; ifill_ack_i = 1'b0;
        ifill_resp_valid_i = 1'b0; ifill_data_i = '0;
        inv_valid_i = 1'b0; inv_paddr_i = '0;
        tick(); tick();
        rst_i = 1'b0;
        #1;
        check("rst.ready", miss_ready_o, 1'b1);
        check("rst.busy", busy_o, 1'b0);
        check("rst.rq_v", ifill_req_valid_o, 1'b0);
        check("rst.wr_en", wr_en_o, 4'b0000);
        check("rst.ovf", inv_ovf_o, 1'b0);
        check("rst.pa", ifill_req_paddr_o, 40'h0);

        // Stray response in IDLE must be ignored.
        ifill_resp_valid_i = 1'b1;
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check("stray.busy", busy_o, 1'b0);
        check("stray.wr_en", wr_en_o, 4'b0000);

        // Basic refill into the first free way (way 2).
        miss_valid_i = 1'b1;
        miss_paddr_i = 40'h80001234;
        way_valid_i  = 4'b1011;
        #1 check("basic.ready", miss_ready_o, 1'b1);
        tick();
        miss_valid_i = 1'b0;
        ifill_ack_i  = 1'b1;
        #1;
        check("basic.rq_v", ifill_req_valid_o, 1'b1);
        check("basic.rq_pa", ifill_req_paddr_o, 40'h80001220);
        check("basic.rq_way", ifill_req_way_o, 2'd2);
        check("basic.busy", busy_o, 1'b1);
        tick();
        ifill_ack_i        = 1'b0;
        ifill_resp_valid_i = 1'b1;
        ifill_data_i       = {8{32'hCAFE_0011}};
        #1 check("basic.wait_en", wr_en_o, 4'b0000);
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check("basic.wr_en", wr_en_o, 4'b0100);
        check("basic.idx", wr_idx_o, 7'h11);
        check("basic.tag", wr_tag_o, 20'h80001);
        check("basic.vbit", wr_vbit_o, 1'b1);
        check("basic.data", wr_data_o, {8{32'hCAFE_0011}});
        check("basic.done", fill_done_o, 1'b1);
        tick();
        #1;
        check("basic.done_off", fill_done_o, 1'b0);
        check("basic.ready2", miss_ready_o, 1'b1);

        // Full set: round-robin victims 0,1,2,3 then wrap to 0.
        do_fill("rr0", 40'h00000040, 40'h00000040, 4'b1111, 2'd0, 4'b0001);
        do_fill("rr1", 40'h00000065, 40'h00000060, 4'b1111, 2'd1, 4'b0010);
        do_fill("rr2", 40'h00000080, 40'h00000080, 4'b1111, 2'd2, 4'b0100);
        do_fill("rr3", 40'h000000BF, 40'h000000A0, 4'b1111, 2'd3, 4'b1000);
        do_fill("rr4", 40'h00000100, 40'h00000100, 4'b1111, 2'd0, 4'b0001);

        // Kill during WAIT: response discarded, no write.
        miss_valid_i = 1'b1;
        miss_paddr_i = 40'h00002000;
        way_valid_i  = 4'b0000;
        tick();
        miss_valid_i = 1'b0;
        ifill_ack_i  = 1'b1;
        tick();
        ifill_ack_i = 1'b0;
        kill_i      = 1'b1;
        tick();
        kill_i             = 1'b0;
        ifill_resp_valid_i = 1'b1;
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check("kill.wr_en", wr_en_o, 4'b0000);
        check("kill.done", fill_done_o, 1'b0);
        check("kill.busy", busy_o, 1'b0);
        check("kill.ready", miss_ready_o, 1'b1);

        // Invalidation of the set being filled drops the fill.
        miss_valid_i = 1'b1;
        miss_paddr_i = 40'h80001234;
        tick();
        miss_valid_i = 1'b0;
        ifill_ack_i  = 1'b1;
        tick();
        ifill_ack_i = 1'b0;
        inv_valid_i = 1'b1;
        inv_paddr_i = 12'h220;
        #1 check("invh.ready", miss_ready_o, 1'b0);
        tick();
        inv_valid_i        = 1'b0;
        ifill_resp_valid_i = 1'b1;
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check("invh.no_wr", wr_en_o, 4'b0000);
        check("invh.pend_rdy", miss_ready_o, 1'b0);
        tick();
        #1;
        check("invh.en", wr_en_o, 4'b1111);
        check("invh.vbit", wr_vbit_o, 1'b0);
        check("invh.idx", wr_idx_o, 7'h11);
        check("invh.done", fill_done_o, 1'b0);
        tick();
        #1;
        check("invh.ready", miss_ready_o, 1'b1);
        check("invh.ovf", inv_ovf_o, 1'b0);

        // Two back-to-back invalidations: second lost, overflow sticky.
        miss_valid_i = 1'b1;
        miss_paddr_i = 40'h80001234;
        tick();
        miss_valid_i = 1'b0;
        ifill_ack_i  = 1'b1;
        tick();
        ifill_ack_i = 1'b0;
        inv_valid_i = 1'b1;
        inv_paddr_i = 12'h040;
        tick();
        inv_paddr_i = 12'h060;
        tick();
        inv_valid_i        = 1'b0;
        ifill_resp_valid_i = 1'b1;
        #1 check("ovf.set", inv_ovf_o, 1'b1);
        tick();
        ifill_resp_valid_i = 1'b0;
        #1;
        check("ovf.fill_en", wr_en_o, 4'b0001);
        check("ovf.fill_idx", wr_idx_o, 7'h11);
        tick();
        tick();
        #1;
        check("ovf.inv_en", wr_en_o, 4'b1111);
        check("ovf.inv_idx", wr_idx_o, 7'h02);
        tick();
        #1;
        check("ovf.sticky", inv_ovf_o, 1'b1);

        // Reset in the middle of REQ abandons the request.
        miss_valid_i = 1'b1;
        miss_paddr_i = 40'h00003000;
        tick();
        miss_valid_i = 1'b0;
        #1 check("mrst.rq_v0", ifill_req_valid_o, 1'b1);
        rst_i = 1'b1;
        tick();
        #1;
        check("mrst.rq_v", ifill_req_valid_o, 1'b0);
        check("mrst.ovf", inv_ovf_o, 1'b0);
        check("mrst.busy", busy_o, 1'b0);
        rst_i       = 1'b0;
        ifill_ack_i = 1'b1;
        ifill_resp_valid_i = 1'b1;
        #1 check("mrst.ready", miss_ready_o, 1'b1);
        tick();
        ifill_ack_i        = 1'b0;
        ifill_resp_valid_i = 1'b0;
        #1;
        check("late.busy", busy_o, 1'b0);
        check("late.wr_en", wr_en_o, 4'b0000);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
